alu_arbiter: RTL

- Shares one 4-bit combinational ALU between two requesters (port 0, port 1) under round-robin arbitration.
- Registers the result into a single response channel with valid/ready backpressure. Result is returned one cycle after acceptance, tagged with the requester ID.
- Sits between the ALU instance and the upstream command sources. It is the only block that drives the ALU operand and select inputs.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 26 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its two-port arbiter front end.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned ALU_SEL_W = 3;

    localparam logic [ALU_SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_SEL_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_SEL_W-1:0] OP_XOR = 3'b100;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned NUM_FLAGS  = 2;

    typedef enum logic {
        StEmpty,
        StFull
    } rsp_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB modulo 2^WIDTH, AND, OR, XOR; unused opcodes yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SEL_W = ALU_SEL_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant advances only when a grant is accepted.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant0,
    output logic grant1
);

    logic last_grant_q;

    // Under contention the port that did not win last time goes next.
    assign grant0 = valid0 & (~valid1 | last_grant_q);
    assign grant1 = valid1 & (~valid0 | ~last_grant_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (advance) begin
            last_grant_q <= grant1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with a registered valid/ready response.
// Optional zero/carry response flags are built when ALU_ARB_FLAGS_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SEL_W = ALU_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
`ifdef ALU_ARB_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_carry,
`endif
    output logic             rsp_id
);

    rsp_state_e       state_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic             rsp_id_q;
    logic             grant0, grant1;
    logic             free, accept;
    logic [WIDTH-1:0] op_a, op_b, alu_y;
    logic [SEL_W-1:0] op_sel;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .advance(accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // A drain and a new accept may share a cycle, so a full register is free if taken.
    assign free       = (state_q == StEmpty) | rsp_ready;
    assign req0_ready = grant0 & free & ~rst;
    assign req1_ready = grant1 & free & ~rst;
    assign accept     = req0_ready | req1_ready;

    assign op_a   = grant1 ? req1_a : req0_a;
    assign op_b   = grant1 ? req1_b : req0_b;
    assign op_sel = grant1 ? req1_sel : req0_sel;

    alu #(
        .WIDTH(WIDTH),
        .SEL_W(SEL_W)
    ) u_alu (
        .a  (op_a),
        .b  (op_b),
        .sel(op_sel),
        .y  (alu_y)
    );

`ifdef ALU_ARB_FLAGS_EN
    logic [WIDTH:0]         sum_ext;
    logic [NUM_FLAGS-1:0]   flags_d, flags_q;

    always_comb begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        flags_d = '0;
        flags_d[FLAG_ZERO] = (alu_y == '0);
        if (op_sel == OP_ADD) begin
            flags_d[FLAG_CARRY] = sum_ext[WIDTH];
        end else if (op_sel == OP_SUB) begin
            flags_d[FLAG_CARRY] = (op_a < op_b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (accept) begin
            flags_q <= flags_d;
        end
    end

    assign rsp_zero  = flags_q[FLAG_ZERO];
    assign rsp_carry = flags_q[FLAG_CARRY];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            rsp_y_q  <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        rsp_y_q  <= alu_y;
                        rsp_id_q <= grant1;
                        state_q  <= StFull;
                    end
                end
                StFull: begin
                    if (accept) begin
                        rsp_y_q  <= alu_y;
                        rsp_id_q <= grant1;
                    end else if (rsp_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

endmodule
